pll_supervisor: RTL
===================

Name: pll_supervisor

Overview:
Sequencer that sits directly upstream of the rPLL wrapper, clocked from the 27 MHz board clock. It drives the PLL's RESET pin and watches its LOCK output. It qualifies lock as stable and issues a lock-qualified ready/system-reset pair to the rest of the design. It also re-resets the PLL on lock loss or lock timeout, and latches a fail flag after repeated timeouts.

Parameters:
PWRUP_CYCLES, 270, pll_reset width after reset release (10 us @27 MHz)
RST_CYCLES, 27, pll_reset width on every re-reset (1 us)
LOCK_TIMEOUT, 27000, max cycles in WAIT_LOCK before a retry (1 ms)
STABLE_CYCLES, 2700, consecutive synced-lock cycles required before ready (100 us)
MAX_RETRY, 4, consecutive timeouts that force FAIL
CNT_W, 16, shared cycle counter width; must hold max of the above
ERR_W, 4, width of relock_cnt

Ports:
clkin  in  1  27 MHz reference clock, free-running
reset  in  1  synchronous, active-high
lock  in  1  PLL LOCK, asynchronous to clkin
pll_reset  out  1  to PLL RESET, active-high
ready  out  1  PLL locked and qualified
sys_reset  out  1  always ~ready; for the downstream reset synchroniser
fail  out  1  sticky; PLL never locked within MAX_RETRY attempts
relock_cnt  out  ERR_W  saturating count of lock losses while in RUN

Behaviour:
- All logic on the clkin rising edge. reset has priority over every other event.
- Reset values: state=PWRUP, cnt=0, retry=0, pll_reset=1, ready=0, sys_reset=1, fail=0, relock_cnt=0. The sync FFs also clear to 0.
- lock passes through a 2-FF synchroniser to give lock_s. The FSM samples lock_s.
  - If raw lock is set up before edge k, the FSM sees lock_s=1 at edge k+2.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.
- pll_reset=1 in states PWRUP, RST and FAIL. ready=1 only in RUN. sys_reset=~ready. fail=1 only in FAIL.
- PWRUP: cnt increments each cycle. At cnt==PWRUP_CYCLES-1, go to WAIT_LOCK with cnt=0.
  - pll_reset is high for exactly PWRUP_CYCLES cycles after reset deasserts.
- RST: same as PWRUP but uses RST_CYCLES.
- WAIT_LOCK:
  - If lock_s=1: go to QUALIFY, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1: increment retry. If the incremented retry==MAX_RETRY, go to FAIL; otherwise go to RST, cnt=0.
  - Else cnt increments.
- QUALIFY:
  - If lock_s=0: go to WAIT_LOCK, cnt=0. The timeout window restarts; retry is unchanged.
  - Else if cnt==STABLE_CYCLES-1: go to RUN and clear retry.
  - Else cnt increments.
  - Net timing: ready rises STABLE_CYCLES edges after the edge that entered QUALIFY, i.e. at edge k+2+STABLE_CYCLES.
  - A lock drop on the completing cycle wins; the FSM goes to WAIT_LOCK, not RUN.
- RUN:
  - If lock_s=0: increment relock_cnt (saturating at all-ones), go to RST, cnt=0.
  - ready falls and pll_reset rises on that same edge.
- FAIL: pll_reset held at 1, ready=0. Only reset exits this state.
- relock_cnt is never cleared except by reset.
- Glitches on lock shorter than one clkin period may be missed. This is acceptable.
- Reset asserted mid-operation (any state) returns to PWRUP on the next edge with all reset values.

Test Plan:
Use PWRUP=5, RST=3, LOCK_TIMEOUT=16, STABLE=4, MAX_RETRY=2, ERR_W=2 for all scenarios.
1. Power-up, then lock=1 driven early. Required: pll_reset high for exactly 5 cycles after reset falls. ready rises 4 edges after the FSM first sees lock_s; sys_reset falls on the same edge; relock_cnt=0.
2. Lock pulse of 2 cycles inside QUALIFY. Required: FSM returns to WAIT_LOCK, ready stays 0. A later steady lock gives ready after a fresh 4-cycle qualify.
3. lock held 0. Required: after 16 WAIT_LOCK cycles, pll_reset pulses for 3 cycles. After the second timeout, fail=1 and pll_reset stays 1. Reset clears fail.
4. In RUN, drop lock for 5 cycles, four times. Required: each drop de-asserts ready and re-pulses pll_reset for 3 cycles. relock_cnt reads 1, 2, 3, 3 (saturated).
5. First attempt times out, second attempt locks. Required: retry clears on entering RUN. A later single timeout does not enter FAIL.
6. Assert reset while in RUN and while in FAIL. Required: on the next edge pll_reset=1, ready=0, fail=0, relock_cnt=0, and the PWRUP count restarts.

Source files
------------

// File: rtl/pll_supervisor.sv
// PLL reset/lock sequencer: holds the PLL in reset after power-up, qualifies lock,
// issues ready/sys_reset, re-resets on lock loss or timeout and latches fail.
//
// state        | meaning
// ST_PWRUP     | initial pll_reset pulse after reset release
// ST_RST       | re-reset pulse after timeout or lock loss
// ST_WAIT_LOCK | PLL released, waiting for synced lock within the timeout window
// ST_QUALIFY   | lock seen, must stay high for STABLE_CYCLES
// ST_RUN       | lock qualified, ready asserted
// ST_FAIL      | too many consecutive timeouts, held until reset
module pll_supervisor #(
    parameter int PWRUP_CYCLES  = 270,
    parameter int RST_CYCLES    = 27,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 2700,
    parameter int MAX_RETRY     = 4,
    parameter int CNT_W         = 16,
    parameter int ERR_W         = 4
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             lock,
    output logic             pll_reset,
    output logic             ready,
    output logic             sys_reset,
    output logic             fail,
    output logic [ERR_W-1:0] relock_cnt
);

    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_RST,
        ST_WAIT_LOCK,
        ST_QUALIFY,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [RTY_W-1:0] retry, retry_d;
    logic [ERR_W-1:0] relock_d;
    logic             lock_m, lock_s;
    logic             pll_reset_d, ready_d, fail_d;

    always_ff @(posedge clkin) begin
        if (reset) begin
            state      <= ST_PWRUP;
            cnt        <= '0;
            retry      <= '0;
            relock_cnt <= '0;
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            pll_reset  <= 1'b1;
            ready      <= 1'b0;
            sys_reset  <= 1'b1;
            fail       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            retry      <= retry_d;
            relock_cnt <= relock_d;
            lock_m     <= lock;
            lock_s     <= lock_m;
            pll_reset  <= pll_reset_d;
            ready      <= ready_d;
            sys_reset  <= ~ready_d;
            fail       <= fail_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        retry_d  = retry;
        relock_d = relock_cnt;
        case (state)
            ST_PWRUP: begin
                if (cnt == PWRUP_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_RST: begin
                if (cnt == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_d = retry + RTY_W'(1);
                    cnt_d   = '0;
                    state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RST;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_QUALIFY: begin
                // a drop on the completing cycle takes priority over entering RUN
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                    if (relock_cnt != '1) begin
                        relock_d = relock_cnt + ERR_W'(1);
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

    // outputs decoded from the next state so they move on the same edge as the state
    always_comb begin
        pll_reset_d = (state_d == ST_PWRUP) || (state_d == ST_RST) || (state_d == ST_FAIL);
        ready_d     = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

endmodule
